// File: rtl/mac_array_acc.sv
// mac_array_acc: multi-lane int8/int4/vsq MAC with per-entry saturating accumulators
module mac_array_acc #(
   parameter int LANES = 16,
   parameter int ELEMS = 32,
   parameter int DEPTH = 16,
   parameter int ACC_W = 24,
   localparam int VW = ELEMS * 8 + 8,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*VW-1:0]    a_vec,
   input  logic [VW-1:0]          b_vec,
   input  logic [1:0]             mode,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*ACC_W-1:0] out_data,
   output logic [IW-1:0]          out_idx,
   output logic                   sat_flag
);
   localparam int TW = 18 + $clog2(ELEMS);
   localparam int XW = ACC_W + TW + 18;
   localparam logic signed [XW-1:0] MAXV = {{(XW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [XW-1:0] MINV = ~MAXV;
   localparam logic [IW-1:0] LASTP = IW'(DEPTH - 1);

   logic stall, acc;
   logic [IW-1:0] ptr, s1_idx;
   logic s1_v, s1_last;
   logic [1:0] s1_mode;
   logic [15:0] s1_scale [LANES];
   logic signed [TW-1:0] term [LANES];
   logic signed [TW-1:0] s1_term [LANES];
   logic signed [ACC_W-1:0] mem [LANES][DEPTH];
   logic signed [ACC_W-1:0] upd [LANES];
   logic signed [XW-1:0] x [LANES];
   logic [LANES-1:0] clamp;

   // one byte pair: full int8 product, or the sum of the two nibble products
   function automatic logic signed [TW-1:0] dot(input logic [7:0] p, input logic [7:0] q, input logic nib);
      logic signed [TW-1:0] full, lo, hi;
      full = TW'($signed(p)) * TW'($signed(q));
      lo = TW'($signed(p[3:0])) * TW'($signed(q[3:0]));
      hi = TW'($signed(p[7:4])) * TW'($signed(q[7:4]));
      return nib ? lo + hi : full;
   endfunction

   assign stall = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign acc = in_valid & in_ready;

   // per-lane dot product of the incoming beat, element 0 starts above the scale byte
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         term[l] = '0;
         for (int k = 0; k < ELEMS; k++)
            term[l] = term[l] + dot(a_vec[l*VW+8+8*k +: 8], b_vec[8+8*k +: 8], mode == 2'b01);
      end
   end

   // S1 register and write pointer, both frozen while the output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_last <= 1'b0;
         s1_mode <= 2'b00;
         s1_idx <= '0;
         ptr <= '0;
         for (int l = 0; l < LANES; l++) begin
            s1_term[l] <= '0;
            s1_scale[l] <= '0;
         end
      end else if (!stall) begin
         s1_v <= acc;
         s1_last <= in_last;
         s1_mode <= mode;
         s1_idx <= ptr;
         for (int l = 0; l < LANES; l++) begin
            s1_term[l] <= term[l];
            s1_scale[l] <= 16'(a_vec[l*VW +: 8]) * 16'(b_vec[7:0]);
         end
         if (acc) ptr <= (ptr == LASTP) ? '0 : ptr + IW'(1);
      end
   end

   // S2 combine: read the entry (last cycle's write already landed), update, saturate
   always_comb begin
      clamp = '0;
      for (int l = 0; l < LANES; l++) begin
         x[l] = s1_mode[1] ? (XW'(mem[l][s1_idx]) * $signed({{(XW-16){1'b0}}, s1_scale[l]})) >>> 8
                           : XW'(mem[l][s1_idx]) + XW'(s1_term[l]);
         clamp[l] = (s1_mode != 2'b11) && (x[l] > MAXV || x[l] < MINV);
         upd[l] = (s1_mode == 2'b11) ? mem[l][s1_idx] :
                  (x[l] > MAXV) ? MAXV[ACC_W-1:0] :
                  (x[l] < MINV) ? MINV[ACC_W-1:0] : x[l][ACC_W-1:0];
      end
   end

   // S2 write-back, output register and sticky saturation flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_idx <= '0;
         sat_flag <= 1'b0;
         for (int l = 0; l < LANES; l++)
            for (int d = 0; d < DEPTH; d++)
               mem[l][d] <= '0;
      end else if (!stall) begin
         out_valid <= s1_v & s1_last;
         if (s1_v) begin
            sat_flag <= sat_flag | (|clamp);
            for (int l = 0; l < LANES; l++)
               mem[l][s1_idx] <= s1_last ? '0 : upd[l];
         end
         if (s1_v & s1_last) begin
            out_idx <= s1_idx;
            for (int l = 0; l < LANES; l++)
               out_data[l*ACC_W +: ACC_W] <= upd[l];
         end
      end
   end
endmodule

// File: tb/tb_mac_array_acc.sv
// tb_mac_array_acc: directed table and sequence bench, DEPTH=16 (d0) and DEPTH=1 (d1) in parallel
module tb_mac_array_acc;
   localparam int LANES = 16;
   localparam int ELEMS = 32;
   localparam int ACC_W = 24;
   localparam int VW = ELEMS * 8 + 8;

   typedef struct {
      logic [1:0] m;
      logic [7:0] a;
      logic [7:0] b;
      int exp;
   } vec_t;

   logic clk, rst_n, in_valid, in_last, out_ready;
   logic [LANES*VW-1:0] a_vec;
   logic [VW-1:0] b_vec;
   logic [1:0] mode;
   logic o0_ready, o0_valid, o0_sat, o1_ready, o1_valid, o1_sat;
   logic [LANES*ACC_W-1:0] o0_data, o1_data;
   logic [3:0] o0_idx;
   logic [0:0] o1_idx;
   int errors = 0;
   int checks = 0;
   int hs = 0;
   vec_t tv [9];

   mac_array_acc #(.LANES(LANES), .ELEMS(ELEMS), .DEPTH(16), .ACC_W(ACC_W)) d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o0_ready), .a_vec(a_vec),
      .b_vec(b_vec), .mode(mode), .in_last(in_last), .out_valid(o0_valid), .out_ready(out_ready),
      .out_data(o0_data), .out_idx(o0_idx), .sat_flag(o0_sat));

   mac_array_acc #(.LANES(LANES), .ELEMS(ELEMS), .DEPTH(1), .ACC_W(ACC_W)) d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o1_ready), .a_vec(a_vec),
      .b_vec(b_vec), .mode(mode), .in_last(in_last), .out_valid(o1_valid), .out_ready(out_ready),
      .out_data(o1_data), .out_idx(o1_idx), .sat_flag(o1_sat));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // counts output handshakes on d0
   always @(posedge clk) if (o0_valid && out_ready) hs <= hs + 1;

   task automatic chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] mkv(input logic [7:0] e, input logic [7:0] sc, input int n);
      logic [VW-1:0] v;
      v = '0;
      v[7:0] = sc;
      for (int k = 0; k < n; k++) v[8+8*k +: 8] = e;
      return v;
   endfunction

   function automatic int lane(input bit d, input int l);
      return d ? int'($signed(o1_data[l*ACC_W +: ACC_W])) : int'($signed(o0_data[l*ACC_W +: ACC_W]));
   endfunction

   task automatic beat(input logic [1:0] m, input logic [LANES*VW-1:0] av, input logic [VW-1:0] bv, input bit last);
      a_vec = av;
      b_vec = bv;
      mode = m;
      in_last = last;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic check_out(input bit d, input int base, input int step, input int idx, input string nm);
      int bad;
      bad = 0;
      chk({nm, ".valid"}, longint'(d ? o1_valid : o0_valid), 1);
      for (int l = LANES - 1; l >= 0; l--) if (lane(d, l) != base + step * l) bad = l;
      chk({nm, ".data"}, lane(d, bad), base + step * bad);
      chk({nm, ".idx"}, d ? longint'(o1_idx) : longint'(o0_idx), idx);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_chk(input string nm);
      chk({nm, ".valid0"}, longint'(o0_valid), 0);
      chk({nm, ".sat0"}, longint'(o0_sat), 0);
      chk({nm, ".ready0"}, longint'(o0_ready), 1);
      chk({nm, ".valid1"}, longint'(o1_valid), 0);
      chk({nm, ".ready1"}, longint'(o1_ready), 1);
      chk({nm, ".data0"}, lane(0, 0), 0);
   endtask

   initial begin
      logic [LANES*VW-1:0] av;
      logic [VW-1:0] bv;
      tv[0] = '{2'b00, 8'h02, 8'h03, 192};
      tv[1] = '{2'b01, 8'h12, 8'h13, 224};
      tv[2] = '{2'b00, 8'hFF, 8'h01, -32};
      tv[3] = '{2'b00, 8'h80, 8'h80, 524288};
      tv[4] = '{2'b00, 8'h7F, 8'h80, -520192};
      tv[5] = '{2'b01, 8'hF8, 8'h7F, 32};
      tv[6] = '{2'b01, 8'h88, 8'h88, 4096};
      tv[7] = '{2'b11, 8'h7F, 8'h7F, 0};
      tv[8] = '{2'b10, 8'h7F, 8'h7F, 0};
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;
      mode = 2'b00;
      a_vec = '0;
      b_vec = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rst_chk("por");

      beat(2'b00, {LANES{mkv(8'h02, 8'h00, 32)}}, mkv(8'h03, 8'h00, 32), 0);
      beat(2'b00, {LANES{mkv(8'h02, 8'h00, 32)}}, mkv(8'h03, 8'h00, 32), 0);
      beat(2'b00, {LANES{mkv(8'h02, 8'h00, 32)}}, mkv(8'h03, 8'h00, 32), 1);
      do_reset();
      rst_chk("midrst");
      beat(2'b00, {LANES{mkv(8'h02, 8'h00, 32)}}, mkv(8'h03, 8'h00, 32), 1);
      @(posedge clk);
      #1;
      check_out(0, 192, 0, 0, "postrst0");
      check_out(1, 192, 0, 0, "postrst1");

      do_reset();
      foreach (tv[i]) begin
         beat(tv[i].m, {LANES{mkv(tv[i].a, 8'h5A, 32)}}, mkv(tv[i].b, 8'hA5, 32), 1);
         @(posedge clk);
         #1;
         check_out(0, tv[i].exp, 0, i, $sformatf("tv%0d", i));
      end
      @(posedge clk);
      #1;
      chk("drop", longint'(o0_valid), 0);

      do_reset();
      for (int l = 0; l < LANES; l++) av[l*VW +: VW] = mkv(8'(l + 1), 8'h00, 32);
      bv = '0;
      for (int k = 0; k < ELEMS; k++) bv[8+8*k +: 8] = 8'(k - 8);
      beat(2'b00, av, bv, 1);
      @(posedge clk);
      #1;
      check_out(0, 240, 240, 0, "lanevary");

      do_reset();
      for (int i = 0; i < 17; i++) beat(2'b00, {LANES{mkv(8'h01, 8'h00, 32)}}, mkv(8'h01, 8'h00, 32), i == 16);
      @(posedge clk);
      #1;
      check_out(0, 64, 0, 0, "wrap");
      check_out(1, 544, 0, 0, "b2b1");
      for (int i = 1; i < 16; i++) begin
         beat(2'b11, '0, '0, 1);
         @(posedge clk);
         #1;
         check_out(0, 32, 0, i, $sformatf("entry%0d", i));
      end

      do_reset();
      for (int i = 0; i < 17; i++) beat(2'b00, {LANES{mkv(8'h80, 8'h00, 32)}}, mkv(8'h80, 8'h00, 32), i == 16);
      @(posedge clk);
      #1;
      check_out(1, 8388607, 0, 0, "sat1");
      check_out(0, 1048576, 0, 0, "nosat0");
      chk("satflag1", longint'(o1_sat), 1);
      chk("satflag0", longint'(o0_sat), 0);
      beat(2'b00, {LANES{mkv(8'h02, 8'h00, 32)}}, mkv(8'h03, 8'h00, 32), 1);
      @(posedge clk);
      #1;
      check_out(1, 192, 0, 0, "aftersat");
      chk("satsticky", longint'(o1_sat), 1);

      do_reset();
      beat(2'b00, {LANES{mkv(8'h05, 8'h00, 8)}}, mkv(8'h19, 8'h00, 8), 0);
      beat(2'b10, {LANES{mkv(8'h33, 8'd16, 32)}}, mkv(8'h44, 8'd32, 32), 0);
      beat(2'b00, '0, '0, 1);
      @(posedge clk);
      #1;
      check_out(1, 2000, 0, 0, "vsqpos");
      beat(2'b00, {LANES{mkv(8'hFB, 8'h00, 8)}}, mkv(8'h19, 8'h00, 8), 0);
      beat(2'b10, {LANES{mkv(8'h00, 8'd1, 32)}}, mkv(8'h00, 8'd1, 32), 0);
      beat(2'b00, '0, '0, 1);
      @(posedge clk);
      #1;
      check_out(1, -4, 0, 0, "vsqneg");

      do_reset();
      out_ready = 1'b0;
      beat(2'b00, {LANES{mkv(8'h02, 8'h00, 32)}}, mkv(8'h03, 8'h00, 32), 1);
      @(posedge clk);
      #1;
      check_out(0, 192, 0, 0, "bp.first");
      hs = 0;
      a_vec = {LANES{mkv(8'h01, 8'h00, 32)}};
      b_vec = mkv(8'h01, 8'h00, 32);
      mode = 2'b00;
      in_last = 1'b1;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp.ready%0d", c), longint'(o0_ready), 0);
         check_out(0, 192, 0, 0, $sformatf("bp.hold%0d", c));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("bp.drop", longint'(o0_valid), 0);
      chk("bp.xfers", hs, 1);
      @(posedge clk);
      #1;
      check_out(0, 32, 0, 1, "bp.next");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
